// File: rtl/counter_seq_checker_pkg.sv
// Shared definitions for the counter sequence checker: FSM encodings and the
// default bus widths used by the counter block, the checker and their benches.
package counter_seq_checker_pkg;

  // Checker states; encodings are fixed so other blocks can decode them.
  typedef enum logic [1:0] {
    ST_ACQUIRE = 2'd0,
    ST_TRACK   = 2'd1,
    ST_FAIL    = 2'd2
  } state_e;

  localparam int unsigned DEF_WIDTH = 4;
  localparam int unsigned DEF_CNT_W = 8;

endpackage

// File: rtl/counter_seq_checker_sat_counter.sv
// Saturating up-counter with synchronous reset and increment enable.
// Once it reaches all-ones it holds there and never wraps back to zero.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] MAX_C = {W{1'b1}};
  localparam logic [W-1:0] ONE_C = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: step by one on request unless already at the ceiling.
  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != MAX_C)) begin
      cnt_d = cnt_q + ONE_C;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= {W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/counter_seq_checker.sv
// Receive-side monitor for a free-running counter bus. Locks onto the first
// qualified sample, then requires each later sample to be the previous +1
// (mod 2^WIDTH). Counts wraps and mismatches and captures the latest bad
// value together with the value that was expected at that point.
module counter_seq_checker
  import counter_seq_checker_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned CNT_W  = DEF_CNT_W,
  parameter bit          RESYNC = 1'b1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic [WIDTH-1:0] COUNTER,
  output logic             LOCKED,
  output logic             FAILED,
  output logic             ERR,
  output logic [CNT_W-1:0] ERR_CNT,
  output logic [CNT_W-1:0] WRAP_CNT,
  output logic [WIDTH-1:0] BAD_VAL,
  output logic [WIDTH-1:0] EXP_VAL
);

  localparam logic [WIDTH-1:0] ONE_C  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ZERO_C = {WIDTH{1'b0}};

  state_e           state_q, state_d;
  logic [WIDTH-1:0] exp_q, exp_d;
  logic             locked_q, locked_d;
  logic             failed_q, failed_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] bad_q, bad_d;
  logic [WIDTH-1:0] expv_q, expv_d;
  logic             err_inc_s;
  logic             wrap_inc_s;
  logic [WIDTH-1:0] next_exp_s;

  assign next_exp_s = COUNTER + ONE_C;

  // FSM next state, expected-value tracking, capture and counter requests.
  always_comb begin
    state_d    = state_q;
    exp_d      = exp_q;
    locked_d   = locked_q;
    failed_d   = failed_q;
    err_d      = 1'b0;
    bad_d      = bad_q;
    expv_d     = expv_q;
    err_inc_s  = 1'b0;
    wrap_inc_s = 1'b0;
    if (EN) begin
      case (state_q)
        ST_ACQUIRE: begin
          // First sample only establishes the sequence; it is never judged.
          exp_d    = next_exp_s;
          locked_d = 1'b1;
          state_d  = ST_TRACK;
        end
        ST_TRACK: begin
          if (COUNTER == exp_q) begin
            exp_d = next_exp_s;
            // A matched zero can only follow all-ones: that is a wrap.
            if (COUNTER == ZERO_C) begin
              wrap_inc_s = 1'b1;
            end else begin
              wrap_inc_s = 1'b0;
            end
          end else begin
            err_d     = 1'b1;
            err_inc_s = 1'b1;
            bad_d     = COUNTER;
            expv_d    = exp_q;
            if (RESYNC) begin
              exp_d = next_exp_s;
            end else begin
              state_d  = ST_FAIL;
              locked_d = 1'b0;
              failed_d = 1'b1;
            end
          end
        end
        ST_FAIL: begin
          // Terminal until reset: everything frozen.
          state_d = ST_FAIL;
        end
        default: begin
          state_d  = ST_ACQUIRE;
          locked_d = 1'b0;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // State, expected value and capture registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= ST_ACQUIRE;
      exp_q    <= ZERO_C;
      locked_q <= 1'b0;
      failed_q <= 1'b0;
      err_q    <= 1'b0;
      bad_q    <= ZERO_C;
      expv_q   <= ZERO_C;
    end else begin
      state_q  <= state_d;
      exp_q    <= exp_d;
      locked_q <= locked_d;
      failed_q <= failed_d;
      err_q    <= err_d;
      bad_q    <= bad_d;
      expv_q   <= expv_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_err_cnt (
    .clk (CLK),
    .rst (RST),
    .inc (err_inc_s),
    .cnt (ERR_CNT)
  );

  sat_counter #(.W(CNT_W)) u_wrap_cnt (
    .clk (CLK),
    .rst (RST),
    .inc (wrap_inc_s),
    .cnt (WRAP_CNT)
  );

  assign LOCKED  = locked_q;
  assign FAILED  = failed_q;
  assign ERR     = err_q;
  assign BAD_VAL = bad_q;
  assign EXP_VAL = expv_q;

endmodule
